libhdl_sync_bus_tx: RTL and testbench
=====================================

# libhdl_sync_bus_tx

Source-side controller for a multi-bit clock-domain crossing using a two-phase (toggle) request/acknowledge handshake. It accepts a word via valid/ready and drives it onto a held-stable bus. It then toggles a request flag and waits for the destination's toggled acknowledge, which it synchronizes internally, before accepting the next word. It sits in front of the destination-side bus synchronizer and guarantees the bus never changes while the destination may be sampling it.

## Interface
Parameters:
- W, 32, data bus width.
- NFF, 2, number of synchronizer flops on the incoming acknowledge (≥2).
- TIMEOUT, 0, cycles spent in WAIT_ACK before o_timeout asserts; 0 disables the timeout.

Ports:
- i_clk  in  1  single clock; all logic is in this domain.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream word available.
- i_data  in  W  upstream word.
- o_ready  out  1  controller can accept a word.
- o_bus  out  W  held data toward the destination domain.
- o_req  out  1  request toggle toward the destination domain.
- i_ack  in  1  acknowledge toggle from the destination domain; asynchronous to i_clk.
- o_busy  out  1  a transfer is in flight (state ≠ IDLE).
- o_timeout  out  1  sticky flag: the current or a past transfer exceeded TIMEOUT cycles.

## Operation
- Reset values: state=IDLE, o_bus=0, o_req=0, o_ready=1, o_busy=0, o_timeout=0, wait counter=0.
- The state machine has three states.
  - IDLE: o_ready=1. On i_valid & o_ready, register i_data into o_bus and go to SETUP.
  - SETUP: o_ready=0. o_bus is stable for one full cycle. Toggle o_req, clear the wait counter, and go to WAIT_ACK.
  - WAIT_ACK: o_ready=0. Compare the synchronized ack (ack_s) with o_req. When they are equal, go to IDLE. Otherwise increment the counter.
- o_bus changes only on the IDLE→SETUP transition. It is never modified in SETUP or WAIT_ACK.
- Timeout: if TIMEOUT>0 and the counter reaches TIMEOUT, set o_timeout. The counter saturates. The controller keeps waiting in WAIT_ACK and never abandons a transfer. o_timeout clears only on i_rst.
- The counter width is $clog2(TIMEOUT+1), with a minimum of 1 bit.
- i_valid with o_ready=0 is ignored. Upstream must hold i_valid and i_data until it sees a handshake.
- An ack_s edge while the controller is in IDLE or SETUP has no effect. It is a protocol violation and is not flagged.
- Reset mid-transfer: the controller returns to IDLE immediately, and o_req goes to 0. The destination side must be reset in the same reset event, or the toggles desynchronize.
- The ack synchronizer flops carry no reset. They power up with INIT_VAL 0, and after i_rst they re-settle to the true i_ack level within NFF cycles.

## Timing
- Let cycle 0 be the cycle in which i_valid & o_ready is sampled high.
- Cycle 1: o_bus = new word, state=SETUP, o_ready=0.
- Cycle 2: o_req toggled, state=WAIT_ACK.
- If i_ack toggles before edge k, ack_s matches o_req after edge k+NFF-1. The controller enters IDLE at edge k+NFF, and o_ready=1 from that cycle.
- Minimum accept-to-accept period: 3 + NFF + destination turnaround cycles.
- o_ready, o_busy, o_req and o_bus are register outputs. There is no combinational path from any input to any output.

## Structure
- Shared package/include libhdl_sync_bus_pkg contains:
  - state encoding localparams (ST_IDLE=2'd0, ST_SETUP=2'd1, ST_WAIT=2'd2);
  - the counter-width function.
- Sub-module: one libhdl_sync_bus instance with W=1, NFF=NFF, INIT_VAL=1'b0 synchronizes i_ack to ack_s. No other synchronization logic is permitted inside this block.
- The reverse-side counterpart, libhdl_sync_bus_rx, is a separate block and is out of scope here.

## Test plan
- Reset: assert i_rst mid-WAIT_ACK -> o_req=0, o_ready=1, o_busy=0, o_bus=0 asynchronously, and o_timeout=0.
- Single transfer, NFF=2: i_data=32'hDEADBEEF with i_valid at cycle 0, and the bench echoes i_ack=o_req after 3 cycles. Required response:
  - o_bus=DEADBEEF at cycle 1;
  - o_req=1 at cycle 2;
  - o_ready=1 exactly NFF cycles after the i_ack edge.
- Back-to-back: i_valid held with 4 words (1,2,3,4) and an ideal echo responder. Required response:
  - o_bus takes the sequence 1,2,3,4;
  - o_req toggles 4 times and ends at 0;
  - o_bus is never modified while o_busy=1.
- Backpressure: i_valid pulses while o_ready=0 -> no o_bus/o_req change; the word is accepted only in IDLE.
- Timeout, TIMEOUT=8: responder silent -> o_timeout=1 after 8 cycles in WAIT_ACK and o_busy stays 1. A late i_ack toggle then returns the controller to IDLE, with o_timeout still 1.
- Spurious ack: toggle i_ack while in IDLE -> no state change and o_bus unchanged. The next valid word still completes when the responder toggles i_ack back to match o_req.

Source files
------------

// File: rtl/libhdl_sync_bus_pkg.sv
// libhdl_sync_bus_pkg: shared state encoding and counter sizing for the toggle-handshake bus crossing.
package libhdl_sync_bus_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    function automatic int cnt_w(input int t);
        return t < 1 ? 1 : $clog2(t + 1);
    endfunction
endpackage

// File: rtl/libhdl_sync_bus.sv
// libhdl_sync_bus: NFF-stage flop synchronizer without reset, powering up at INIT_VAL.
module libhdl_sync_bus #(
    parameter int W = 1,
    parameter int NFF = 2,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic         i_clk,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);
    logic [NFF-1:0][W-1:0] ff = {NFF{INIT_VAL}};

    always_ff @(posedge i_clk)
        ff <= {ff[NFF-2:0], i_data};

    assign o_data = ff[NFF-1];
endmodule

// File: rtl/libhdl_sync_bus_tx.sv
// libhdl_sync_bus_tx: source side of a two-phase req/ack crossing that holds the bus stable per transfer.
module libhdl_sync_bus_tx
    import libhdl_sync_bus_pkg::*;
#(
    parameter int W = 32,
    parameter int NFF = 2,
    parameter int TIMEOUT = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic [W-1:0] o_bus,
    output logic         o_req,
    input  logic         i_ack,
    output logic         o_busy,
    output logic         o_timeout
);
    localparam int CW = cnt_w(TIMEOUT);
    localparam logic [CW-1:0] CMAX = TIMEOUT > 0 ? CW'(TIMEOUT) : {CW{1'b1}};

    state_t state;
    logic ack_s;
    logic [CW-1:0] cnt;

    libhdl_sync_bus #(.W(1), .NFF(NFF), .INIT_VAL(1'b0)) u_ack_sync (
        .i_clk (i_clk),
        .i_data(i_ack),
        .o_data(ack_s)
    );

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            state     <= ST_IDLE;
            o_bus     <= '0;
            o_req     <= 1'b0;
            o_ready   <= 1'b1;
            o_busy    <= 1'b0;
            o_timeout <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: if (i_valid) begin
                    o_bus   <= i_data;
                    state   <= ST_SETUP;
                    o_ready <= 1'b0;
                    o_busy  <= 1'b1;
                end
                ST_SETUP: begin
                    o_req <= ~o_req;
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: if (ack_s == o_req) begin
                    state   <= ST_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end else begin
                    if (cnt != CMAX) cnt <= cnt + 1'b1;
                    // flag on the increment that lands on TIMEOUT; saturation keeps it from re-firing
                    if (TIMEOUT > 0 && cnt == CMAX - 1'b1) o_timeout <= 1'b1;
                end
                default: begin
                    state   <= ST_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_libhdl_sync_bus_tx.sv
// tb_libhdl_sync_bus_tx: directed stimulus with a queue scoreboard checking each word presented on o_req toggles.
module tb_libhdl_sync_bus_tx;
    localparam int W = 32;
    localparam int NFF = 2;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic ack = 1'b0;
    logic [W-1:0] data = '0;
    logic ready, req, busy, tmo;
    logic [W-1:0] bus;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    bit echo_en = 1'b0;
    logic last_req = 1'b0;
    logic prev_busy = 1'b0;
    logic [W-1:0] prev_bus = '0;

    libhdl_sync_bus_tx #(.W(W), .NFF(NFF), .TIMEOUT(TMO)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid),
        .i_data   (data),
        .o_ready  (ready),
        .o_bus    (bus),
        .o_req    (req),
        .i_ack    (ack),
        .o_busy   (busy),
        .o_timeout(tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        int n;
        logic r;
        valid = 1'b1;
        data = d;
        exp_q.push_back(d);
        n = 0;
        do begin
            r = ready;
            step();
            n++;
        end while (!r && n < 200);
        chk("send_handshake", {31'd0, r}, 32'd1);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 200) begin
            step();
            n++;
        end
        chk("wait_ready", {31'd0, ready}, 32'd1);
    endtask

    // ideal destination: echoes the request a couple of ns after each edge
    initial forever begin
        @(posedge clk);
        #2;
        if (echo_en && ack !== req) ack = req;
    end

    // scoreboard monitor: every request toggle presents a new word on the bus
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) last_req = req;
        else begin
            if (req !== last_req) begin
                last_req = req;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got %h want none", bus);
                end else chk("sb_bus", bus, exp_q.pop_front());
            end
            if (prev_busy) chk("bus_hold", bus, prev_bus);
        end
        prev_busy = busy;
        prev_bus = bus;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_bus", bus, 32'd0);
        chk("rst_tmo", {31'd0, tmo}, 32'd0);
        rst = 1'b0;
        step();
        step();

        send(32'hDEADBEEF);
        valid = 1'b0;
        chk("s_bus", bus, 32'hDEADBEEF);
        chk("s_ready", {31'd0, ready}, 32'd0);
        step();
        chk("s_req", {31'd0, req}, 32'd1);
        repeat (3) step();
        ack = 1'b1;
        step();
        step();
        chk("s_ready_early", {31'd0, ready}, 32'd0);
        step();
        chk("s_ready_nff", {31'd0, ready}, 32'd1);

        send(32'h000000A5);
        valid = 1'b0;
        step();
        repeat (7) step();
        chk("t_tmo_early", {31'd0, tmo}, 32'd0);
        step();
        chk("t_tmo_set", {31'd0, tmo}, 32'd1);
        chk("t_busy", {31'd0, busy}, 32'd1);
        repeat (5) step();
        chk("t_busy_hold", {31'd0, busy}, 32'd1);
        ack = 1'b0;
        wait_ready();
        chk("t_tmo_sticky", {31'd0, tmo}, 32'd1);

        send(32'h12345678);
        valid = 1'b0;
        repeat (4) step();
        #2 rst = 1'b1;
        #1;
        chk("r_ready", {31'd0, ready}, 32'd1);
        chk("r_busy", {31'd0, busy}, 32'd0);
        chk("r_req", {31'd0, req}, 32'd0);
        chk("r_bus", bus, 32'd0);
        chk("r_tmo", {31'd0, tmo}, 32'd0);
        repeat (3) step();
        rst = 1'b0;
        step();

        echo_en = 1'b1;
        for (int i = 1; i <= 4; i++) send(i);
        valid = 1'b0;
        wait_ready();
        chk("b2b_req", {31'd0, req}, 32'd0);
        chk("b2b_drain", exp_q.size(), 32'd0);

        echo_en = 1'b0;
        send(32'hAAAA0001);
        valid = 1'b0;
        step();
        step();
        valid = 1'b1;
        data = 32'hBBBB0002;
        step();
        valid = 1'b0;
        chk("bp_bus", bus, 32'hAAAA0001);
        chk("bp_req", {31'd0, req}, 32'd1);
        chk("bp_ready", {31'd0, ready}, 32'd0);
        ack = 1'b1;
        wait_ready();
        echo_en = 1'b1;
        send(32'hBBBB0002);
        valid = 1'b0;
        wait_ready();
        chk("bp_bus2", bus, 32'hBBBB0002);

        echo_en = 1'b0;
        ack = 1'b1;
        repeat (4) step();
        chk("sp_ready", {31'd0, ready}, 32'd1);
        chk("sp_busy", {31'd0, busy}, 32'd0);
        chk("sp_bus", bus, 32'hBBBB0002);
        chk("sp_req", {31'd0, req}, 32'd0);
        echo_en = 1'b1;
        send(32'hCCCC0003);
        valid = 1'b0;
        wait_ready();
        step();
        chk("sp_bus2", bus, 32'hCCCC0003);
        chk("sp_req2", {31'd0, req}, 32'd1);
        chk("final_drain", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
